// File: rtl/my_buffer_command_unit_pkg.sv
// Shared command codes, button indices and FSM states for the buffer command unit.
// The CTRL_* codes match the associative buffer's command decoder.
package my_buffer_command_unit_pkg;

    localparam int MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH = 3;

    localparam logic [2:0] CTRL_NOP  = 3'd0;
    localparam logic [2:0] CTRL_CLR  = 3'd1;
    localparam logic [2:0] CTRL_LOAD = 3'd2;
    localparam logic [2:0] CTRL_INCR = 3'd3;
    localparam logic [2:0] CTRL_DECR = 3'd4;

    localparam int NUM_BUTTONS = 4;
    localparam int BTN_LOAD    = 0;
    localparam int BTN_INCR    = 1;
    localparam int BTN_DECR    = 2;
    localparam int BTN_DISPLAY = 3;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ISSUE        = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    // Lowest-index press wins; DISPLAY alone maps to NOP because it only pulses trigger_display.
    function automatic logic [2:0] command_for_press(input logic [NUM_BUTTONS-1:0] press);
        if (press[BTN_LOAD]) begin
            return CTRL_LOAD;
        end else if (press[BTN_INCR]) begin
            return CTRL_INCR;
        end else if (press[BTN_DECR]) begin
            return CTRL_DECR;
        end else begin
            return CTRL_NOP;
        end
    endfunction

endpackage

// File: rtl/my_debouncer.sv
// One active-low button: 2-FF synchroniser, stability counter and debounced level.
// press_pulse is a single-cycle flag registered together with a released-to-pressed flip.
module my_debouncer #(
    parameter int DEBOUNCE_TICKS = 500_000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic button_n,
    output logic level,
    output logic press_pulse
);

    localparam logic [CNT_WIDTH-1:0] LAST_TICK = CNT_WIDTH'(DEBOUNCE_TICKS - 1);

    logic                 sync_meta;
    logic                 sync_level;
    logic [CNT_WIDTH-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta  <= 1'b1;
            sync_level <= 1'b1;
        end else begin
            sync_meta  <= button_n;
            sync_level <= sync_meta;
        end
    end

    // Any bounce back to the accepted level restarts the count, so only a clean run flips it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_cnt  <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync_level == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST_TICK) begin
                stable_cnt  <= '0;
                level       <= sync_level;
                press_pulse <= ~sync_level;
            end else begin
                stable_cnt <= stable_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/my_buffer_command_unit.sv
// Turns raw DE0 buttons and switches into single-cycle associative-buffer commands,
// holding key/data steady from the command cycle until every button is released.
module my_buffer_command_unit
    import my_buffer_command_unit_pkg::*;
#(
    parameter int CTRL_WIDTH     = MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH,
    parameter int KEY_WIDTH      = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int DEBOUNCE_TICKS = 500_000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            buttons_n,
    input  logic [KEY_WIDTH-1:0]  key_switches,
    input  logic [DATA_WIDTH-1:0] data_switches,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [KEY_WIDTH-1:0]  key_output,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic                  trigger_display,
    output logic                  busy
);

    logic [NUM_BUTTONS-1:0] levels;
    logic [NUM_BUTTONS-1:0] press;
    logic [KEY_WIDTH-1:0]   key_meta;
    logic [KEY_WIDTH-1:0]   key_sync;
    logic [DATA_WIDTH-1:0]  data_meta;
    logic [DATA_WIDTH-1:0]  data_sync;

    state_t                 state;
    state_t                 state_next;
    logic [CTRL_WIDTH-1:0]  ctrl_next;
    logic                   trigger_next;
    logic                   load_fields;
    logic [2:0]             press_cmd;

    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_button
        my_debouncer #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_debouncer (
            .clk         (clk),
            .rst         (rst),
            .button_n    (buttons_n[b]),
            .level       (levels[b]),
            .press_pulse (press[b])
        );
    end

    // Switches are only synchronised; they feed a live lookup so bounce is harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_meta  <= '0;
            key_sync  <= '0;
            data_meta <= '0;
            data_sync <= '0;
        end else begin
            key_meta  <= key_switches;
            key_sync  <= key_meta;
            data_meta <= data_switches;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        ctrl_next    = CTRL_WIDTH'(CTRL_NOP);
        trigger_next = 1'b0;
        load_fields  = 1'b0;
        press_cmd    = command_for_press(press);
        case (state)
            ST_IDLE: begin
                if (|press) begin
                    state_next = ST_ISSUE;
                    if (press_cmd == CTRL_NOP) begin
                        trigger_next = 1'b1;
                    end else begin
                        ctrl_next = CTRL_WIDTH'(press_cmd);
                    end
                end else begin
                    load_fields = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (&levels) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so ctrl lines up with the ISSUE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl            <= CTRL_WIDTH'(CTRL_NOP);
            trigger_display <= 1'b0;
            busy            <= 1'b0;
            key_output      <= '0;
            data_output     <= '0;
        end else begin
            ctrl            <= ctrl_next;
            trigger_display <= trigger_next;
            busy            <= (state_next != ST_IDLE);
            if (load_fields) begin
                key_output  <= key_sync;
                data_output <= data_sync;
            end
        end
    end

endmodule

// File: tb/tb_my_buffer_command_unit.sv
// Directed and random bench for my_buffer_command_unit with a timestamp-based
// debounce model; every cycle is compared against the model's expected outputs.
module tb_my_buffer_command_unit;
    import my_buffer_command_unit_pkg::*;

    localparam int TICKS = 4;
    localparam int CW    = MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    buttons_n = 4'hF;
    logic [7:0]    key_switches = 8'h00;
    logic [7:0]    data_switches = 8'h00;
    logic [CW-1:0] ctrl;
    logic [7:0]    key_output;
    logic [7:0]    data_output;
    logic          trigger_display;
    logic          busy;

    int errors = 0;
    int checks = 0;
    string phase = "init";

    // Model: sync delay line, debounced levels flipping after TICKS stable edges, command flag.
    int            edge_n = 0;
    logic [3:0]    m_s1, m_s2, m_lvl, m_pulse;
    int            m_chg [4];
    logic [7:0]    m_k1, m_k2, m_d1, m_d2;
    bit            m_busy, m_just;
    logic [CW-1:0] e_ctrl;
    logic          e_trig, e_busy;
    logic [7:0]    e_key, e_data;

    int n_cmd, n_load, n_incr, n_decr, n_trig, n_trig_ctrl;

    my_buffer_command_unit #(
        .CTRL_WIDTH     (CW),
        .KEY_WIDTH      (8),
        .DATA_WIDTH     (8),
        .DEBOUNCE_TICKS (TICKS),
        .CNT_WIDTH      (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .buttons_n       (buttons_n),
        .key_switches    (key_switches),
        .data_switches   (data_switches),
        .ctrl            (ctrl),
        .key_output      (key_output),
        .data_output     (data_output),
        .trigger_display (trigger_display),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s/%s: observed=%0h expected=%0h", phase, name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'hF; m_pulse = 4'h0;
        for (int b = 0; b < 4; b++) m_chg[b] = edge_n;
        m_k1 = 8'h00; m_k2 = 8'h00; m_d1 = 8'h00; m_d2 = 8'h00;
        m_busy = 1'b0; m_just = 1'b0;
        e_ctrl = CTRL_NOP; e_trig = 1'b0; e_busy = 1'b0; e_key = 8'h00; e_data = 8'h00;
    endtask

    task automatic model_edge();
        logic [3:0] nl;
        logic [3:0] np;
        nl = m_lvl;
        np = 4'h0;
        for (int b = 0; b < 4; b++) begin
            if (m_s2[b] != m_lvl[b] && (edge_n - m_chg[b]) >= TICKS) begin
                nl[b] = m_s2[b];
                np[b] = ~m_s2[b];
            end
        end
        e_ctrl = CTRL_NOP;
        e_trig = 1'b0;
        if (!m_busy) begin
            if (m_pulse != 4'h0) begin
                m_busy = 1'b1;
                m_just = 1'b1;
                if (m_pulse[0])      e_ctrl = CTRL_LOAD;
                else if (m_pulse[1]) e_ctrl = CTRL_INCR;
                else if (m_pulse[2]) e_ctrl = CTRL_DECR;
                else                 e_trig = 1'b1;
            end else begin
                e_key  = m_k2;
                e_data = m_d2;
            end
        end else if (m_just) begin
            m_just = 1'b0;
        end else if (m_lvl == 4'hF) begin
            m_busy = 1'b0;
        end
        e_busy = m_busy;
        for (int b = 0; b < 4; b++) if (m_s1[b] != m_s2[b]) m_chg[b] = edge_n;
        m_s2 = m_s1; m_s1 = buttons_n;
        m_k2 = m_k1; m_k1 = key_switches;
        m_d2 = m_d1; m_d1 = data_switches;
        m_lvl = nl;
        m_pulse = np;
        edge_n++;
    endtask

    task automatic check_output();
        chk("ctrl", 32'(ctrl), 32'(e_ctrl));
        chk("trigger_display", 32'(trigger_display), 32'(e_trig));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("key_output", 32'(key_output), 32'(e_key));
        chk("data_output", 32'(data_output), 32'(e_data));
    endtask

    task automatic clear_tally();
        n_cmd = 0; n_load = 0; n_incr = 0; n_decr = 0; n_trig = 0; n_trig_ctrl = 0;
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
        if (ctrl != CTRL_NOP || trigger_display) n_cmd++;
        if (ctrl == CTRL_LOAD) n_load++;
        if (ctrl == CTRL_INCR) n_incr++;
        if (ctrl == CTRL_DECR) n_decr++;
        if (trigger_display) n_trig++;
        if (trigger_display && ctrl != CTRL_NOP) n_trig_ctrl++;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        check_output();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        clear_tally();
        phase = "reset";
        do_reset();

        phase = "clean_load";
        key_switches = 8'h3C;
        data_switches = 8'hA5;
        repeat (5) apply_stimulus();
        clear_tally();
        for (int t = 1; t <= 40; t++) begin
            apply_stimulus();
            if (t == 16) chk("ctrl_before", 32'(ctrl), 32'(CTRL_NOP));
            if (t == 17) begin
                chk("ctrl_load", 32'(ctrl), 32'(CTRL_LOAD));
                chk("key_at_cmd", 32'(key_output), 32'h3C);
                chk("data_at_cmd", 32'(data_output), 32'hA5);
            end
            if (t == 18) chk("ctrl_after", 32'(ctrl), 32'(CTRL_NOP));
            if (t == 36) chk("busy_held", 32'(busy), 32'd1);
            if (t == 37) chk("busy_fall", 32'(busy), 32'd0);
            if (t == 10) buttons_n[0] = 1'b0;
            if (t == 30) buttons_n[0] = 1'b1;
        end
        chk("load_count", 32'(n_load), 32'd1);

        phase = "bouncy_incr";
        clear_tally();
        for (int t = 1; t <= 45; t++) begin
            apply_stimulus();
            if (t == 18) chk("no_cmd_bounce", 32'(n_cmd), 32'd0);
            if (t == 19) chk("ctrl_incr", 32'(ctrl), 32'(CTRL_INCR));
            if (t <= 12)      buttons_n[1] = 1'((t / 2) % 2);
            else if (t < 30)  buttons_n[1] = 1'b0;
            else              buttons_n[1] = 1'b1;
        end
        chk("incr_count", 32'(n_incr), 32'd1);
        chk("cmd_count", 32'(n_cmd), 32'd1);

        phase = "simultaneous";
        clear_tally();
        for (int t = 1; t <= 65; t++) begin
            apply_stimulus();
            if (t == 9) chk("ctrl_load", 32'(ctrl), 32'(CTRL_LOAD));
            if (t == 42) chk("ctrl_decr", 32'(ctrl), 32'(CTRL_DECR));
            if (t == 2) buttons_n = 4'b1010;
            if (t == 20) buttons_n = 4'b1111;
            if (t == 35) buttons_n[2] = 1'b0;
            if (t == 50) buttons_n[2] = 1'b1;
        end
        chk("load_count", 32'(n_load), 32'd1);
        chk("decr_count", 32'(n_decr), 32'd1);
        chk("cmd_count", 32'(n_cmd), 32'd2);

        phase = "display";
        clear_tally();
        for (int t = 1; t <= 125; t++) begin
            apply_stimulus();
            if (t == 9) begin
                chk("trigger", 32'(trigger_display), 32'd1);
                chk("ctrl_nop", 32'(ctrl), 32'(CTRL_NOP));
            end
            if (t == 2) buttons_n[3] = 1'b0;
            if (t == 102) buttons_n[3] = 1'b1;
        end
        chk("trig_count", 32'(n_trig), 32'd1);
        chk("trig_with_ctrl", 32'(n_trig_ctrl), 32'd0);
        chk("cmd_count", 32'(n_cmd), 32'd1);

        phase = "frozen";
        key_switches = 8'h11;
        data_switches = 8'h5A;
        repeat (4) apply_stimulus();
        for (int t = 1; t <= 40; t++) begin
            apply_stimulus();
            if (t == 9 || t == 20 || t == 31) chk("key_frozen", 32'(key_output), 32'h11);
            if (t == 31) chk("busy_wait", 32'(busy), 32'd1);
            if (t == 32) chk("busy_idle", 32'(busy), 32'd0);
            if (t == 33) chk("key_live", 32'(key_output), 32'h22);
            if (t == 2) buttons_n[0] = 1'b0;
            if (t == 12) key_switches = 8'h22;
            if (t == 25) buttons_n[0] = 1'b1;
        end

        phase = "reset_mid_issue";
        clear_tally();
        for (int t = 1; t <= 8; t++) begin
            apply_stimulus();
            if (t == 1) buttons_n[1] = 1'b0;
        end
        chk("ctrl_incr", 32'(ctrl), 32'(CTRL_INCR));
        buttons_n = 4'hF;
        do_reset();
        clear_tally();
        repeat (15) apply_stimulus();
        chk("quiet_after_reset", 32'(n_cmd), 32'd0);

        phase = "held_across_reset";
        buttons_n[2] = 1'b0;
        do_reset();
        clear_tally();
        for (int t = 1; t <= 35; t++) begin
            apply_stimulus();
            if (t == 7) chk("ctrl_decr", 32'(ctrl), 32'(CTRL_DECR));
            if (t == 20) buttons_n[2] = 1'b1;
        end
        chk("decr_count", 32'(n_decr), 32'd1);
        chk("cmd_count", 32'(n_cmd), 32'd1);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            int hold;
            buttons_n = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                key_switches = 8'($urandom);
                data_switches = 8'($urandom);
            end
            hold = $urandom_range(1, 9);
            repeat (hold) apply_stimulus();
            if ($urandom_range(0, 79) == 0) do_reset();
        end
        buttons_n = 4'hF;
        repeat (20) apply_stimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
